dct_da_stream: RTL

//  Parametrised, handshaked successor to the fixed 8-point bit-serial distributed-arithmetic (DA) DCT.

---
 rtl/dct_da_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/dct_da_stream.sv
// dct_da_stream: bit-serial distributed-arithmetic DCT over 8-sample blocks with valid/ready output.
module dct_da_stream #(
   parameter int DATA_W   = 8,
   parameter int COEF_W   = 16,
   parameter int ACC_W    = 19,
   parameter int NUM_COEF = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*DATA_W-1:0]   in_data,
   output logic [2:0]            rom_k,
   output logic [2:0]            rom_addr1,
   output logic [2:0]            rom_addr2,
   input  logic [COEF_W-1:0]     rom_data1,
   input  logic [COEF_W-1:0]     rom_data2,
   input  logic [COEF_W-1:0]     rom_off,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [2:0]            out_idx,
   output logic                  out_last
);
   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
   localparam logic [2:0] K_LAST = 3'(NUM_COEF - 1);
   state_t state;
   logic [8*DATA_W-1:0] hold, sr, sr_sh;
   logic [7:0] xb;
   logic [ACC_W-1:0] acc, acc_nxt, t_ext, off_ext;
   logic [COEF_W:0] r1, r2, n1, n2, t;
   logic [2:0] k;
   logic [BW-1:0] bcnt;
   always_comb begin
      xb = '0;
      sr_sh = '0;
      for (int i = 0; i < 8; i++) begin
         xb[i] = sr[i*DATA_W];
         sr_sh[i*DATA_W +: DATA_W] = {1'b0, sr[i*DATA_W+1 +: DATA_W-1]};
      end
   end
   // ROM words are widened by one bit first so negating the most negative word stays exact
   assign r1 = {rom_data1[COEF_W-1], rom_data1};
   assign r2 = {rom_data2[COEF_W-1], rom_data2};
   assign n1 = (r1 ^ {(COEF_W+1){xb[0]}}) + (COEF_W+1)'(xb[0]);
   assign n2 = (r2 ^ {(COEF_W+1){xb[4]}}) + (COEF_W+1)'(xb[4]);
   assign t = n1 + n2;
   assign t_ext = {{(ACC_W-COEF_W-1){t[COEF_W]}}, t};
   assign off_ext = {{(ACC_W-COEF_W){rom_off[COEF_W-1]}}, rom_off};
   assign acc_nxt = t_ext + {acc[ACC_W-1], acc[ACC_W-1:1]};
   assign rom_k = state == CALC ? k : 3'd0;
   assign rom_addr1 = state == CALC ? {xb[0]^xb[1], xb[0]^xb[2], xb[0]^xb[3]} : 3'd0;
   assign rom_addr2 = state == CALC ? {xb[4]^xb[5], xb[4]^xb[6], xb[4]^xb[7]} : 3'd0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         acc       <= '0;
         k         <= '0;
         bcnt      <= '0;
         hold      <= '0;
         sr        <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               hold     <= in_data;
               sr       <= in_data;
               acc      <= '0;
               k        <= '0;
               bcnt     <= '0;
               in_ready <= 1'b0;
               state    <= CALC;
            end
            CALC: begin
               acc  <= acc_nxt;
               sr   <= sr_sh;
               bcnt <= bcnt + 1'b1;
               if (bcnt == B_LAST) begin
                  out_data  <= acc_nxt + off_ext;
                  out_idx   <= k;
                  out_last  <= k == K_LAST;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               if (k == K_LAST) begin
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  k     <= k + 1'b1;
                  sr    <= hold;
                  acc   <= '0;
                  bcnt  <= '0;
                  state <= CALC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
